// File: rtl/adder_pkg.sv
// Shared types and default widths for the chunked multicycle adder.
package adder_pkg;

    localparam int unsigned DefaultInputWidth = 32;
    localparam int unsigned DefaultChunkWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/adder_input_if.sv
// Operand handshake between a producer (master) and the multicycle adder (slave).
interface adder_input_if
    import adder_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = DefaultInputWidth
);

    logic                        inputs_valid;
    logic                        inputs_ready;
    logic [INPUT_DATA_WIDTH-1:0] in1;
    logic [INPUT_DATA_WIDTH-1:0] in2;

    modport master (output inputs_valid, output in1, output in2, input inputs_ready);
    modport slave  (input inputs_valid, input in1, input in2, output inputs_ready);

endinterface

// File: rtl/adder_output_if.sv
// Result bus driven by the multicycle adder (master); overflow flag exists only when
// MULTICYCLE_ADDER_OVERFLOW_EN is defined.
interface adder_output_if
    import adder_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = DefaultInputWidth
);

    logic [INPUT_DATA_WIDTH:0] out;
    logic                      output_valid;

`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    logic overflow;

    modport master (output out, output output_valid, output overflow);
    modport slave  (input out, input output_valid, input overflow);
`else
    modport master (output out, output output_valid);
    modport slave  (input out, input output_valid);
`endif

endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK_WIDTH-bit adder with carry-in and carry-out.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = DefaultChunkWidth
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   carry_in,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + (CHUNK_WIDTH + 1)'(carry_in);

endmodule

// File: rtl/multicycle_adder.sv
// Adds two operands one CHUNK_WIDTH slice per clock, LSB slice first.
// Optional signed-overflow flag is enabled by defining MULTICYCLE_ADDER_OVERFLOW_EN.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = DefaultInputWidth,
    parameter int unsigned CHUNK_WIDTH      = DefaultChunkWidth
) (
    input  logic          clk,
    input  logic          reset,
    adder_input_if.slave  in_if,
    adder_output_if.master out_if
);

    localparam int unsigned OUTPUT_DATA_WIDTH = INPUT_DATA_WIDTH + 1;
    localparam int unsigned NUM_CHUNKS        = INPUT_DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned CntWidth          = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if ((INPUT_DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk_width
        $error("INPUT_DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    state_e                       state_q;
    logic [INPUT_DATA_WIDTH-1:0]  a_q;
    logic [INPUT_DATA_WIDTH-1:0]  b_q;
    logic [INPUT_DATA_WIDTH-1:0]  acc_q;
    logic                         carry_q;
    logic [CntWidth-1:0]          cnt_q;
    logic [OUTPUT_DATA_WIDTH-1:0] out_q;
    logic                         valid_q;
    logic                         ready_q;

    logic [CHUNK_WIDTH-1:0]       chunk_sum;
    logic                         chunk_carry;
    logic [INPUT_DATA_WIDTH-1:0]  acc_next;
    logic                         last_chunk;
    logic                         accept;

    // Operands shift right so the active slice is always the low CHUNK_WIDTH bits.
    chunk_adder #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a         (a_q[CHUNK_WIDTH-1:0]),
        .b         (b_q[CHUNK_WIDTH-1:0]),
        .carry_in  (carry_q),
        .sum       (chunk_sum),
        .carry_out (chunk_carry)
    );

    // Partial sums enter at the top and shift down; after NUM_CHUNKS steps they are in place.
    assign acc_next   = (acc_q >> CHUNK_WIDTH)
                      | (INPUT_DATA_WIDTH'(chunk_sum) << (INPUT_DATA_WIDTH - CHUNK_WIDTH));
    assign last_chunk = (cnt_q == CntWidth'(NUM_CHUNKS - 1));
    assign accept     = in_if.inputs_valid && ready_q;

`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (state_q != StBusy) begin
            if (accept) begin
                a_msb_q <= in_if.in1[INPUT_DATA_WIDTH-1];
                b_msb_q <= in_if.in2[INPUT_DATA_WIDTH-1];
            end
        end else if (last_chunk) begin
            overflow_q <= (a_msb_q == b_msb_q) && (acc_next[INPUT_DATA_WIDTH-1] != a_msb_q);
        end
    end

    assign out_if.overflow = overflow_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        a_q     <= in_if.in1;
                        b_q     <= in_if.in2;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StBusy: begin
                    a_q     <= a_q >> CHUNK_WIDTH;
                    b_q     <= b_q >> CHUNK_WIDTH;
                    acc_q   <= acc_next;
                    carry_q <= chunk_carry;
                    if (last_chunk) begin
                        cnt_q   <= '0;
                        out_q   <= {chunk_carry, acc_next};
                        valid_q <= 1'b1;
                        state_q <= StDone;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_if.inputs_ready  = ready_q;
    assign out_if.out          = out_q;
    assign out_if.output_valid = valid_q;

endmodule
